// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: branch condition codes,
// FSM state encoding and latency limits.
package mem_stage_pkg;

  localparam logic [2:0] BR_NE = 3'b000;
  localparam logic [2:0] BR_EQ = 3'b001;
  localparam logic [2:0] BR_GT = 3'b010;
  localparam logic [2:0] BR_LT = 3'b011;
  localparam logic [2:0] BR_GE = 3'b100;
  localparam logic [2:0] BR_LE = 3'b101;
  localparam logic [2:0] BR_OV = 3'b110;
  localparam logic [2:0] BR_UN = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } memStateT;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

  // Any request that touches the data memory (load, store or both).
  function automatic logic isMemOp(input logic memRead, input logic memWrite);
    return memRead | memWrite;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: maps a 3-bit condition code and
// the N/Z/V flags to a taken/not-taken decision. Kept separate so an early
// branch unit can reuse it.
module branch_cond_eval
  import mem_stage_pkg::*;
(
  input  logic [2:0] branch_op,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       cond
);

  // Decode the condition code against the flags.
  always_comb begin
    cond = 1'b0;
    case (branch_op)
      BR_NE:   cond = ~z;
      BR_EQ:   cond = z;
      BR_GT:   cond = ~z & ~n;
      BR_LT:   cond = n;
      BR_GE:   cond = z | ~n;
      BR_LE:   cond = z | n;
      BR_OV:   cond = v;
      BR_UN:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_mc.sv
// Memory-access stage: word-addressed data memory with a fixed multi-cycle
// latency, a busy FSM that stalls upstream, a result pipe feeding WB and a
// combinational branch resolution path towards fetch.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              saw_branch,
  input  logic [2:0]        branch_op,
  input  logic              flag_n,
  input  logic              flag_z,
  input  logic              flag_v,
  output logic              stall,
  output logic              pc_src,
  output logic              out_valid,
  output logic [DATA_W-1:0] read_data
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam bit              MULTI    = (LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = MULTI ? CNT_W'(LATENCY - 2) : '0;

  memStateT          state;
  memStateT          stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic [IDX_W-1:0]  idx;
  logic              memOp;
  logic              canAccept;
  logic              accept;
  logic              acceptMem;
  logic              acceptStore;
  logic              acceptLoad;
  logic              acceptNonMem;
  logic              condTaken;
  logic              unusedBits;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LATENCY-1:0] pipeValid;
  logic [LATENCY-1:0] pipeLoad;
  logic [DATA_W-1:0]  pipeData [LATENCY];

  // Upper address bits wrap away; the last stage's load flag has no consumer
  // because that stage's data register is the read_data output itself.
  assign idx        = address[IDX_W-1:0];
  assign unusedBits = &{1'b0, address[ADDR_W-1:IDX_W], pipeLoad[LATENCY-1]};

  branch_cond_eval uCond (
    .branch_op (branch_op),
    .n         (flag_n),
    .z         (flag_z),
    .v         (flag_v),
    .cond      (condTaken)
  );

  // Acceptance window: idle, or the final busy cycle where the count has
  // drained. A read+write request is treated purely as a store.
  always_comb begin
    memOp        = isMemOp(mem_read, mem_write);
    canAccept    = (state == ST_IDLE) || (cnt == '0);
    accept       = in_valid & canAccept & ~rst;
    acceptMem    = accept & memOp;
    acceptStore  = accept & mem_write;
    acceptLoad   = accept & mem_read & ~mem_write;
    acceptNonMem = accept & ~memOp;
  end

  // Stall is raised when a multi-cycle access starts from idle and held while
  // the count is still draining; an access taken in the final busy cycle has
  // already been consumed, so it does not need the upstream to hold.
  always_comb begin
    stall  = 1'b0;
    pc_src = 1'b0;
    if (!rst) begin
      stall  = ((state == ST_IDLE) & in_valid & memOp & MULTI) |
               ((state == ST_BUSY) & (cnt != '0));
      pc_src = accept & saw_branch & condTaken;
    end
  end

  // Busy FSM next-state: count down the remaining stall cycles, re-arm when a
  // new access arrives in the final busy cycle.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      ST_IDLE: begin
        if (acceptMem && MULTI) begin
          stateNext = ST_BUSY;
          cntNext   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cntNext = cnt - CNT_W'(1);
        end else if (acceptMem && MULTI) begin
          cntNext = CNT_LOAD;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // FSM state and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (acceptStore) begin
      mem[idx] <= write_data;
    end
  end

  // Result pipe: memory accesses enter stage 0 and emerge LATENCY cycles
  // later, non-memory instructions enter the last stage so they complete in
  // one cycle. Data only advances behind a load so read_data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipeValid <= '0;
      pipeLoad  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipeData[k] <= '0;
      end
    end else begin
      pipeValid[0] <= acceptMem | (acceptNonMem & (LATENCY == 1));
      pipeLoad[0]  <= acceptLoad;
      if (acceptLoad) begin
        pipeData[0] <= mem[idx];
      end
      for (int k = 1; k < LATENCY; k++) begin
        pipeValid[k] <= pipeValid[k-1] | (acceptNonMem & (k == LATENCY - 1));
        pipeLoad[k]  <= pipeLoad[k-1];
        if (pipeLoad[k-1]) begin
          pipeData[k] <= pipeData[k-1];
        end
      end
    end
  end

  assign out_valid = pipeValid[LATENCY-1];
  assign read_data = pipeData[LATENCY-1];

endmodule
